dmem_ctrl: RTL and testbench

- Data-memory access unit directly downstream of the load/store buffer.
- Takes one load/store at a time from the LSB head over the DC_sgn/DC_sgn_in handshake.
- Performs it byte-serially on the 8-bit RAM bus through the memory arbiter.
- Returns completion to the LSB; broadcasts load results on the CDBD common data bus.

---
 rtl/dmem_ctrl_pkg.sv | 18 +
 rtl/dmem_ext.sv | 41 ++++
 rtl/dmem_ctrl.sv | 136 +++++++++++++
 tb/tb_dmem_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared constants for the data-memory access unit: memory opcodes and FSM state encoding.
package dmem_ctrl_pkg;

  localparam logic [5:0] OP_LB  = 6'd11;
  localparam logic [5:0] OP_LH  = 6'd12;
  localparam logic [5:0] OP_LW  = 6'd13;
  localparam logic [5:0] OP_LBU = 6'd14;
  localparam logic [5:0] OP_LHU = 6'd15;
  localparam logic [5:0] OP_SB  = 6'd16;
  localparam logic [5:0] OP_SH  = 6'd17;
  localparam logic [5:0] OP_SW  = 6'd18;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/dmem_ext.sv
// Opcode decode for the memory unit: access size in bytes, load/store class,
// and sign/zero extension of the little-endian assembled load bytes.
module dmem_ext
  import dmem_ctrl_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [31:0] raw_i,
  output logic [31:0] result_o,
  output logic [2:0]  size_o,
  output logic        is_load_o
);

  function automatic logic [31:0] sext8(input logic [7:0] b);
    logic signed [7:0] s;
    s = b;
    return 32'(s);
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] h);
    logic signed [15:0] s;
    s = h;
    return 32'(s);
  endfunction

  always_comb begin
    result_o  = '0;
    size_o    = 3'd4;
    is_load_o = 1'b0;
    case (opcode_i)
      OP_LB:  begin result_o = sext8(raw_i[7:0]);    size_o = 3'd1; is_load_o = 1'b1; end
      OP_LBU: begin result_o = {24'd0, raw_i[7:0]};  size_o = 3'd1; is_load_o = 1'b1; end
      OP_LH:  begin result_o = sext16(raw_i[15:0]);  size_o = 3'd2; is_load_o = 1'b1; end
      OP_LHU: begin result_o = {16'd0, raw_i[15:0]}; size_o = 3'd2; is_load_o = 1'b1; end
      OP_LW:  begin result_o = raw_i;                size_o = 3'd4; is_load_o = 1'b1; end
      OP_SB:  size_o = 3'd1;
      OP_SH:  size_o = 3'd2;
      default: size_o = 3'd4;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-serial load/store engine between the LSB head and the 8-bit RAM arbiter port;
// load results are broadcast on the CDB, completion is pulsed back to the LSB.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int ROB_W  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              lsb_req,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_val,
  input  logic [5:0]        lsb_opcode,
  input  logic [ROB_W-1:0]  lsb_rob_name,
  output logic              lsb_done,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic [7:0]        mem_din,
  output logic              cdb_sgn,
  output logic [31:0]       cdb_result,
  output logic [ROB_W-1:0]  cdb_rob_name,
  input  logic              jp_wrong
);

  logic [1:0]        state_q, state_d;
  logic [2:0]        k_q, k_d;
  logic [31:0]       data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       val_q, val_d;
  logic [5:0]        opc_q, opc_d;
  logic [ROB_W-1:0]  tag_q, tag_d;

  logic [5:0]  dec_opc;
  logic [31:0] ext_result;
  logic [2:0]  size;
  logic        is_load;
  logic        last_beat;
  logic        addr_beat;
  logic        done_ok;
  logic [2:0]  k_prev;

  // In IDLE the decoder looks at the incoming op; afterwards at the latched one.
  assign dec_opc = (state_q == ST_IDLE) ? lsb_opcode : opc_q;

  dmem_ext u_ext (
    .opcode_i  (dec_opc),
    .raw_i     (data_q),
    .result_o  (ext_result),
    .size_o    (size),
    .is_load_o (is_load)
  );

  assign k_prev    = k_q - 3'd1;
  assign last_beat = is_load ? (k_q == size) : (k_q == size - 3'd1);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    data_d  = data_q;
    addr_d  = addr_q;
    val_d   = val_q;
    opc_d   = opc_q;
    tag_d   = tag_q;
    case (state_q)
      ST_IDLE: begin
        if (lsb_req && !jp_wrong) begin
          addr_d  = lsb_addr;
          val_d   = lsb_val;
          opc_d   = lsb_opcode;
          tag_d   = lsb_rob_name;
          data_d  = '0;
          k_d     = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (is_load && jp_wrong) begin
          state_d = ST_IDLE;
        end else if (mem_gnt) begin
          k_d     = '0;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (is_load && jp_wrong) begin
          state_d = ST_IDLE;
        end else begin
          // Read data trails its address by one cycle, so beat k lands byte k-1.
          if (is_load && (k_q != 3'd0)) data_d[{k_prev[1:0], 3'b000} +: 8] = mem_din;
          if (last_beat) state_d = ST_DONE;
          else           k_d     = k_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      data_q  <= '0;
    end else if (rdy) begin
      state_q <= state_d;
      k_q     <= k_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rdy) begin
      addr_q <= addr_d;
      val_q  <= val_d;
      opc_q  <= opc_d;
      tag_q  <= tag_d;
    end
  end

  assign addr_beat = (state_q == ST_XFER) && (k_q < size);
  assign done_ok   = (state_q == ST_DONE) && !(is_load && jp_wrong);

  assign mem_req      = (state_q == ST_REQ) || (state_q == ST_XFER);
  assign mem_wr       = (state_q == ST_XFER) && !is_load;
  assign mem_a        = addr_beat ? addr_q + ADDR_W'(k_q) : '0;
  assign mem_dout     = (addr_beat && !is_load) ? val_q[{k_q[1:0], 3'b000} +: 8] : 8'd0;
  assign lsb_done     = done_ok;
  assign cdb_sgn      = done_ok && is_load;
  assign cdb_result   = (done_ok && is_load) ? ext_result : 32'd0;
  assign cdb_rob_name = (done_ok && is_load) ? tag_q : '0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: store/load beats, extension, grant wait, flush,
// back-to-back acceptance, reset abort and rdy stall, against hand-computed values.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        lsb_req;
  logic [31:0] lsb_addr, lsb_val;
  logic [5:0]  lsb_opcode;
  logic [3:0]  lsb_rob_name;
  logic        lsb_done, mem_req, mem_gnt, mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, mem_din;
  logic        cdb_sgn;
  logic [31:0] cdb_result;
  logic [3:0]  cdb_rob_name;
  logic        jp_wrong;

  logic [7:0] ram [0:4095];
  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int cdb_cnt = 0;
  int wr_cnt = 0;
  int d0, c0, w0;

  dmem_ctrl #(.ROB_W(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .lsb_req(lsb_req), .lsb_addr(lsb_addr), .lsb_val(lsb_val),
    .lsb_opcode(lsb_opcode), .lsb_rob_name(lsb_rob_name), .lsb_done(lsb_done),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_a(mem_a), .mem_dout(mem_dout),
    .mem_wr(mem_wr), .mem_din(mem_din),
    .cdb_sgn(cdb_sgn), .cdb_result(cdb_result), .cdb_rob_name(cdb_rob_name),
    .jp_wrong(jp_wrong)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_din <= ram[mem_a[11:0]];

  always @(negedge clk) begin
    if (lsb_done) done_cnt <= done_cnt + 1;
    if (cdb_sgn)  cdb_cnt  <= cdb_cnt + 1;
    if (mem_wr)   wr_cnt   <= wr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] v,
                       input logic [3:0] tag);
    lsb_req      = 1'b1;
    lsb_opcode   = op;
    lsb_addr     = a;
    lsb_val      = v;
    lsb_rob_name = tag;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_req"},  32'(mem_req), 32'd0);
    chk({tag, "_wr"},   32'(mem_wr), 32'd0);
    chk({tag, "_a"},    mem_a, 32'd0);
    chk({tag, "_dout"}, 32'(mem_dout), 32'd0);
    chk({tag, "_done"}, 32'(lsb_done), 32'd0);
    chk({tag, "_cdb"},  32'(cdb_sgn), 32'd0);
    chk({tag, "_res"},  cdb_result, 32'd0);
    chk({tag, "_tag"},  32'(cdb_rob_name), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    rst = 1'b1; rdy = 1'b1; lsb_req = 1'b0; lsb_addr = '0; lsb_val = '0;
    lsb_opcode = '0; lsb_rob_name = '0; mem_gnt = 1'b1; jp_wrong = 1'b0;
    step(); step();
    chk_quiet("reset");
    rst = 1'b0;
    step();

    // SW 0xDEADBEEF @0x100, grant already high
    d0 = done_cnt; c0 = cdb_cnt;
    issue(OP_SW, 32'h100, 32'hDEADBEEF, 4'd1);
    step();
    chk("sw_c1_req", 32'(mem_req), 32'd1);
    chk("sw_c1_wr", 32'(mem_wr), 32'd0);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] v;
      v = 32'hDEADBEEF;
      step();
      chk("sw_beat_wr", 32'(mem_wr), 32'd1);
      chk("sw_beat_a", mem_a, 32'h100 + 32'(k));
      chk("sw_beat_dout", 32'(mem_dout), 32'(v[8*k +: 8]));
      chk("sw_beat_req", 32'(mem_req), 32'd1);
    end
    step();
    chk("sw_c6_done", 32'(lsb_done), 32'd1);
    chk("sw_c6_cdb", 32'(cdb_sgn), 32'd0);
    chk("sw_c6_req", 32'(mem_req), 32'd0);
    lsb_req = 1'b0;
    step();
    chk("sw_c7_done", 32'(lsb_done), 32'd0);
    chk("sw_ndone", 32'(done_cnt - d0), 32'd1);
    chk("sw_ncdb", 32'(cdb_cnt - c0), 32'd0);

    // LB / LBU of 0x80 @0x200
    ram[12'h200] = 8'h80;
    issue(OP_LB, 32'h200, 32'h0, 4'd5);
    step(); step();
    chk("lb_c2_a", mem_a, 32'h200);
    chk("lb_c2_wr", 32'(mem_wr), 32'd0);
    step();
    chk("lb_c3_done", 32'(lsb_done), 32'd0);
    chk("lb_c3_req", 32'(mem_req), 32'd1);
    step();
    chk("lb_c4_cdb", 32'(cdb_sgn), 32'd1);
    chk("lb_c4_done", 32'(lsb_done), 32'd1);
    chk("lb_c4_res", cdb_result, 32'hFFFFFF80);
    chk("lb_c4_tag", 32'(cdb_rob_name), 32'd5);
    lsb_req = 1'b0;
    step();
    chk("lb_c5_cdb", 32'(cdb_sgn), 32'd0);
    issue(OP_LBU, 32'h200, 32'h0, 4'd6);
    step(); step(); step(); step();
    chk("lbu_c4_cdb", 32'(cdb_sgn), 32'd1);
    chk("lbu_c4_res", cdb_result, 32'h00000080);
    chk("lbu_c4_tag", 32'(cdb_rob_name), 32'd6);
    lsb_req = 1'b0;
    step();

    // LH @0x1FF with grant withheld for three cycles
    ram[12'h1FF] = 8'h34; ram[12'h200] = 8'h12;
    w0 = wr_cnt;
    mem_gnt = 1'b0;
    issue(OP_LH, 32'h1FF, 32'h0, 4'd3);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk("lh_wait_req", 32'(mem_req), 32'd1);
      chk("lh_wait_a", mem_a, 32'd0);
    end
    mem_gnt = 1'b1;
    step();
    chk("lh_b0_a", mem_a, 32'h1FF);
    step();
    chk("lh_b1_a", mem_a, 32'h200);
    step();
    chk("lh_b2_req", 32'(mem_req), 32'd1);
    chk("lh_b2_done", 32'(lsb_done), 32'd0);
    step();
    chk("lh_done", 32'(lsb_done), 32'd1);
    chk("lh_res", cdb_result, 32'h00001234);
    chk("lh_nwr", 32'(wr_cnt - w0), 32'd0);
    lsb_req = 1'b0;
    step();

    // LW flushed in XFER beat 2
    d0 = done_cnt; c0 = cdb_cnt;
    issue(OP_LW, 32'h300, 32'h0, 4'd7);
    step(); step(); step(); step();
    chk("lwf_b2_a", mem_a, 32'h302);
    jp_wrong = 1'b1; lsb_req = 1'b0;
    step();
    jp_wrong = 1'b0;
    chk("lwf_req", 32'(mem_req), 32'd0);
    chk("lwf_done", 32'(lsb_done), 32'd0);
    step(); step(); step(); step();
    chk("lwf_ndone", 32'(done_cnt - d0), 32'd0);
    chk("lwf_ncdb", 32'(cdb_cnt - c0), 32'd0);

    // SW ignores the same flush pulse
    issue(OP_SW, 32'h340, 32'hA1B2C3D4, 4'd8);
    step(); step(); step(); step();
    jp_wrong = 1'b1;
    step();
    jp_wrong = 1'b0;
    chk("swf_b3_wr", 32'(mem_wr), 32'd1);
    chk("swf_b3_a", mem_a, 32'h343);
    chk("swf_b3_dout", 32'(mem_dout), 32'hA1);
    step();
    chk("swf_done", 32'(lsb_done), 32'd1);
    lsb_req = 1'b0;
    step();

    // SH wrapping past the top of the address space
    issue(OP_SH, 32'hFFFFFFFF, 32'h0000BEEF, 4'd2);
    step(); step();
    chk("shw_b0_a", mem_a, 32'hFFFFFFFF);
    chk("shw_b0_dout", 32'(mem_dout), 32'hEF);
    step();
    chk("shw_b1_a", mem_a, 32'h0);
    chk("shw_b1_dout", 32'(mem_dout), 32'hBE);
    step();
    chk("shw_done", 32'(lsb_done), 32'd1);
    lsb_req = 1'b0;
    step();

    // Back-to-back SBs with lsb_req held through the done pulse
    d0 = done_cnt;
    issue(OP_SB, 32'h500, 32'h000000AA, 4'd1);
    step(); step();
    chk("b2b_1_dout", 32'(mem_dout), 32'hAA);
    step();
    chk("b2b_1_done", 32'(lsb_done), 32'd1);
    issue(OP_SB, 32'h501, 32'h00000055, 4'd2);
    step();
    chk("b2b_idle_req", 32'(mem_req), 32'd0);
    chk("b2b_idle_done", 32'(lsb_done), 32'd0);
    step();
    chk("b2b_2_req", 32'(mem_req), 32'd1);
    step();
    chk("b2b_2_a", mem_a, 32'h501);
    chk("b2b_2_dout", 32'(mem_dout), 32'h55);
    step();
    chk("b2b_2_done", 32'(lsb_done), 32'd1);
    lsb_req = 1'b0;
    step();
    chk("b2b_ndone", 32'(done_cnt - d0), 32'd2);
    chk("b2b_after_req", 32'(mem_req), 32'd0);

    // Reset in the middle of an LW transfer
    d0 = done_cnt; c0 = cdb_cnt;
    issue(OP_LW, 32'h600, 32'h0, 4'd9);
    step(); step(); step();
    chk("rst_pre_a", mem_a, 32'h601);
    rst = 1'b1;
    step();
    chk_quiet("rst_mid");
    rst = 1'b0; lsb_req = 1'b0;
    step(); step(); step(); step(); step();
    chk("rst_ndone", 32'(done_cnt - d0), 32'd0);
    chk("rst_ncdb", 32'(cdb_cnt - c0), 32'd0);

    // rdy low for two cycles during SW beat 1
    issue(OP_SW, 32'h400, 32'h11223344, 4'd4);
    step(); step(); step();
    chk("stall_c3_a", mem_a, 32'h401);
    rdy = 1'b0;
    step();
    chk("stall_c4_a", mem_a, 32'h401);
    chk("stall_c4_wr", 32'(mem_wr), 32'd1);
    step();
    chk("stall_c5_a", mem_a, 32'h401);
    chk("stall_c5_dout", 32'(mem_dout), 32'h33);
    rdy = 1'b1;
    step();
    chk("stall_c6_a", mem_a, 32'h402);
    step();
    chk("stall_c7_a", mem_a, 32'h403);
    chk("stall_c7_done", 32'(lsb_done), 32'd0);
    step();
    chk("stall_c8_done", 32'(lsb_done), 32'd1);
    lsb_req = 1'b0;
    step();
    chk("stall_c9_done", 32'(lsb_done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
